button_debounce_multi: RTL and testbench

BUTTON_DEBOUNCE_MULTI -- requirements
Module: button_debounce_multi

---
 rtl/button_debounce_multi.sv | 69 ++++++
 tb/tb_button_debounce_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: per-channel two-flop synchroniser, stability-count debouncer,
// press/release edge pulses and saturating long-press detection.
module button_debounce_multi #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] button_in,
    output logic [N-1:0] button_out,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SW-1:0] r_cnt;
        logic [HW-1:0] r_hold;
        logic          r_out;
        logic          r_press;
        logic          r_release;
        logic          w_diff;
        logic          w_flip;

        assign w_diff = r_sync2[i] ^ r_out;
        // The flip edge is the STABLE_CYCLES-th consecutive mismatch; the count restarts there.
        assign w_flip = w_diff && (r_cnt == STABLE_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt     <= '0;
                r_hold    <= '0;
                r_out     <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_cnt     <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
                r_out     <= w_flip ? r_sync2[i] : r_out;
                r_press   <= w_flip && r_sync2[i];
                r_release <= w_flip && !r_sync2[i];
                r_hold    <= !r_out ? '0 : (r_hold == LONG_MAX) ? r_hold : r_hold + 1'b1;
            end
        end

        assign button_out[i]    = r_out;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_release;
        // Gated by r_out so long-press drops on the same edge the debounced level falls.
        assign long_press[i]    = r_out && (r_hold == LONG_MAX);
    end
endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: scenario tasks plus randomized traffic, checked against a
// window-based reference model (flip when the last STABLE_CYCLES synced samples all differ).
module tb_button_debounce_multi;
    localparam int N = 4;
    localparam int S = 16;
    localparam int L = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] button_in = '0;
    logic [N-1:0] button_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_press;

    int n_checks = 0;
    int n_fail   = 0;

    button_debounce_multi #(.N(N), .STABLE_CYCLES(S), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .button_in(button_in), .button_out(button_out),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Reference model: q[0] is the raw sample of the previous edge, so q[1..S] are the
    // synchronised values seen over the last S edges.
    logic [N-1:0] q[$];
    logic [N-1:0] m_out = '0, m_press = '0, m_rel = '0, m_long = '0;
    int           m_hold[N];

    always @(posedge clk) begin
        logic [N-1:0] nout;
        bit           stable;
        if (rst) begin
            q = {};
            for (int j = 0; j <= S; j++) q.push_back('0);
            m_out = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < N; c++) m_hold[c] = 0;
        end else begin
            nout = m_out;
            for (int c = 0; c < N; c++) begin
                stable = 1'b1;
                for (int j = 1; j <= S; j++) if (q[j][c] == m_out[c]) stable = 1'b0;
                if (stable) nout[c] = ~m_out[c];
                m_hold[c] = m_out[c] ? ((m_hold[c] < L) ? m_hold[c] + 1 : L) : 0;
            end
            m_press = nout & ~m_out;
            m_rel   = m_out & ~nout;
            m_out   = nout;
            for (int c = 0; c < N; c++) m_long[c] = m_out[c] && (m_hold[c] == L);
            q.push_front(button_in);
            void'(q.pop_back());
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        button_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (button_out !== '0) begin n_fail++; $display("FAIL reset_out got %b want 0", button_out); end
        n_checks++; if (press_pulse !== '0) begin n_fail++; $display("FAIL reset_press got %b want 0", press_pulse); end
        n_checks++; if (release_pulse !== '0) begin n_fail++; $display("FAIL reset_release got %b want 0", release_pulse); end
        n_checks++; if (long_press !== '0) begin n_fail++; $display("FAIL reset_long got %b want 0", long_press); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clean_press;
        int lat, np, nr, other;
        lat = -1; np = 0; other = 0;
        button_in[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if ({button_out, press_pulse, release_pulse, long_press} !== {m_out, m_press, m_rel, m_long}) begin
                n_fail++; $display("FAIL clean_model t=%0t got %b want %b", $time,
                    {button_out, press_pulse, release_pulse, long_press}, {m_out, m_press, m_rel, m_long});
            end
            if (lat < 0 && button_out[0]) lat = k;
            np += int'(press_pulse[0]);
            if (button_out[3:1] !== 3'b000) other++;
        end
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL clean_latency got %0d want 18", lat); end
        n_checks++; if (np != 1) begin n_fail++; $display("FAIL clean_press_count got %0d want 1", np); end
        n_checks++; if (other != 0) begin n_fail++; $display("FAIL clean_other_channels got %0d want 0", other); end
        lat = -1; nr = 0;
        button_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (lat < 0 && !button_out[0]) lat = k;
            nr += int'(release_pulse[0]);
        end
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL clean_release_latency got %0d want 18", lat); end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL clean_release_count got %0d want 1", nr); end
    endtask

    task automatic test_bounce;
        int total, w, lat, np, early;
        logic level;
        total = 0; level = 1'b0; early = 0; lat = -1; np = 0;
        while (total < 100 || level) begin
            w = $urandom_range(1, 10);
            level = ~level;
            button_in[1] = level;
            repeat (w) begin
                @(negedge clk);
                if (button_out[1] || press_pulse[1]) early++;
            end
            total += w;
        end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL bounce_stable got %0d high cycles want 0", early); end
        button_in[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if ({button_out, press_pulse, release_pulse, long_press} !== {m_out, m_press, m_rel, m_long}) begin
                n_fail++; $display("FAIL bounce_model t=%0t got %b want %b", $time,
                    {button_out, press_pulse, release_pulse, long_press}, {m_out, m_press, m_rel, m_long});
            end
            if (lat < 0 && button_out[1]) lat = k;
            np += int'(press_pulse[1]);
        end
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL bounce_latency got %0d want 18", lat); end
        n_checks++; if (np != 1) begin n_fail++; $display("FAIL bounce_press_count got %0d want 1", np); end
        button_in = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_long_press;
        int t_out, t_long, nr, fell_ok;
        logic prev_long;
        t_out = -1; t_long = -1; nr = 0; fell_ok = 0; prev_long = 1'b0;
        button_in[2] = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            n_checks++;
            if ({button_out, press_pulse, release_pulse, long_press} !== {m_out, m_press, m_rel, m_long}) begin
                n_fail++; $display("FAIL long_model t=%0t got %b want %b", $time,
                    {button_out, press_pulse, release_pulse, long_press}, {m_out, m_press, m_rel, m_long});
            end
            if (t_out < 0 && button_out[2]) t_out = k;
            if (t_long < 0 && long_press[2]) t_long = k;
        end
        n_checks++;
        if (t_out < 0 || t_long < 0 || t_long - t_out != L) begin
            n_fail++; $display("FAIL long_delay got out=%0d long=%0d want gap %0d", t_out, t_long, L);
        end
        button_in[2] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            nr += int'(release_pulse[2]);
            if (release_pulse[2] && prev_long && !long_press[2] && !button_out[2]) fell_ok++;
            prev_long = long_press[2];
        end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL long_release_count got %0d want 1", nr); end
        n_checks++; if (fell_ok != 1) begin n_fail++; $display("FAIL long_fall_together got %0d want 1", fell_ok); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_short_press;
        int np, nr, nl;
        np = 0; nr = 0; nl = 0;
        button_in[3] = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            if (k == 101) button_in[3] = 1'b0;
            @(negedge clk);
            np += int'(press_pulse[3]);
            nr += int'(release_pulse[3]);
            nl += int'(long_press[3]);
        end
        n_checks++; if (np != 1) begin n_fail++; $display("FAIL short_press_count got %0d want 1", np); end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL short_release_count got %0d want 1", nr); end
        n_checks++; if (nl != 0) begin n_fail++; $display("FAIL short_long got %0d want 0", nl); end
    endtask

    task automatic test_reset_mid;
        int lat0, lat2, budget, np0, np2;
        lat0 = -1; lat2 = -1; budget = 0; np0 = 0; np2 = 0;
        button_in[2] = 1'b1;
        while (!long_press[2] && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        n_checks++; if (!long_press[2]) begin n_fail++; $display("FAIL rstmid_long_timeout got %b want 1", long_press[2]); end
        button_in[0] = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({button_out, press_pulse, release_pulse, long_press} !== '0) begin
            n_fail++; $display("FAIL rstmid_clear got %b want 0", {button_out, press_pulse, release_pulse, long_press});
        end
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            n_checks++;
            if ({button_out, press_pulse, release_pulse, long_press} !== {m_out, m_press, m_rel, m_long}) begin
                n_fail++; $display("FAIL rstmid_model t=%0t got %b want %b", $time,
                    {button_out, press_pulse, release_pulse, long_press}, {m_out, m_press, m_rel, m_long});
            end
            if (lat0 < 0 && button_out[0]) lat0 = k;
            if (lat2 < 0 && button_out[2]) lat2 = k;
            np0 += int'(press_pulse[0]);
            np2 += int'(press_pulse[2]);
        end
        n_checks++; if (lat0 != 18) begin n_fail++; $display("FAIL rstmid_ch0_latency got %0d want 18", lat0); end
        n_checks++; if (lat2 != 18) begin n_fail++; $display("FAIL rstmid_ch2_latency got %0d want 18", lat2); end
        n_checks++; if (np0 + np2 != 2) begin n_fail++; $display("FAIL rstmid_press_count got %0d want 2", np0 + np2); end
        button_in = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int t_rise, t_fall;
        t_rise = -1; t_fall = -1;
        button_in = '1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (t_rise < 0 && button_out != '0) begin
                t_rise = k;
                n_checks++;
                if (button_out !== '1 || press_pulse !== '1) begin
                    n_fail++; $display("FAIL simul_rise got out=%b press=%b want all ones", button_out, press_pulse);
                end
            end
        end
        n_checks++; if (t_rise != 18) begin n_fail++; $display("FAIL simul_latency got %0d want 18", t_rise); end
        button_in = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (t_fall < 0 && button_out != '1) begin
                t_fall = k;
                n_checks++;
                if (button_out !== '0 || release_pulse !== '1) begin
                    n_fail++; $display("FAIL simul_fall got out=%b release=%b want 0/all ones", button_out, release_pulse);
                end
            end
        end
        n_checks++; if (t_fall != 18) begin n_fail++; $display("FAIL simul_fall_latency got %0d want 18", t_fall); end
    endtask

    task automatic test_random;
        int dur[N];
        for (int c = 0; c < N; c++) dur[c] = $urandom_range(1, 40);
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    button_in[c] = ~button_in[c];
                    dur[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 350) : $urandom_range(1, 20);
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            n_checks++;
            if ({button_out, press_pulse, release_pulse, long_press} !== {m_out, m_press, m_rel, m_long}) begin
                n_fail++; $display("FAIL random_model t=%0t got %b want %b", $time,
                    {button_out, press_pulse, release_pulse, long_press}, {m_out, m_press, m_rel, m_long});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_long_press;
        test_short_press;
        test_reset_mid;
        test_simultaneous;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
